// File: rtl/instr_fetch_decode_pkg.sv
// Shared opcode constants, instruction field positions and FSM encoding
// for the fetch/decode front end. No logic, so no latency.
// No flow control lives here.
package instr_fetch_decode_pkg;

    // Opcode field position inside the 32-bit instruction word
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int OPCODE_W  = OPCODE_HI - OPCODE_LO + 1;

    // Opcodes the control ROM implements; everything else is illegal
    localparam logic [OPCODE_W-1:0] OP_4  = 6'd4;
    localparam logic [OPCODE_W-1:0] OP_5  = 6'd5;
    localparam logic [OPCODE_W-1:0] OP_11 = 6'd11;
    localparam logic [OPCODE_W-1:0] OP_12 = 6'd12;
    localparam logic [OPCODE_W-1:0] OP_15 = 6'd15;
    localparam logic [OPCODE_W-1:0] OP_24 = 6'd24;
    localparam logic [OPCODE_W-1:0] OP_36 = 6'd36;
    localparam logic [OPCODE_W-1:0] OP_60 = 6'd60;

    // Front-end sequencing states
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } state_e;

endpackage

// File: rtl/instr_fetch_decode_opcode_onehot_enc.sv
// Opcode to one-hot decoder masked by the supported opcode set.
// Purely combinational, zero latency.
// No flow control; output follows the input opcode.
module opcode_onehot_enc
    import instr_fetch_decode_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output logic [63:0]         onehot,
    output logic                legal
);

    // Illegal opcodes decode to an all-zero vector so the ROM sees no line
    always_comb begin
        legal  = 1'b0;
        onehot = '0;
        case (opcode)
            OP_4, OP_5, OP_11, OP_12, OP_15, OP_24, OP_36, OP_60: legal = 1'b1;
            default:                                               legal = 1'b0;
        endcase
        if (legal) begin
            onehot[opcode] = 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: req/ack fetch from imem, one-hot opcode out on valid/ready.
// Latency: dec_valid rises the edge after imem_ack; best case 2 cycles per instruction.
// Backpressure: dec_onehot held stable while dec_ready is low; no new fetch until handshake.
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                TIMEOUT  = 15,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [63:0]       dec_onehot,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic              illegal,
    output logic              fetch_err,
    output logic [15:0]       retired
);

    // Wait counter only has to reach TIMEOUT-1: the TIMEOUT-th unacked
    // cycle is detected while the counter holds TIMEOUT-1.
    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e              state_q,   state_d;
    logic [ADDR_W-1:0]   pc_q,      pc_d;
    logic                req_q,     req_d;
    logic                valid_q,   valid_d;
    logic [OPCODE_W-1:0] op_q,      op_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic                illegal_q, illegal_d;
    logic                err_q,     err_d;
    logic [15:0]         retired_q, retired_d;

    logic                op_legal;
    logic                unused_rdata_low;

    // Only the opcode field of the fetched word is consumed here
    assign unused_rdata_low = ^imem_rdata[OPCODE_LO-1:0];

    // Decode straight off the opcode register, so dec_onehot only moves
    // on the edge that captures a new word
    opcode_onehot_enc u_enc (
        .opcode (op_q),
        .onehot (dec_onehot),
        .legal  (op_legal)
    );

    // Next-state and registered-output computation for the fetch/issue FSM
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_d     = req_q;
        valid_d   = valid_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        err_d     = err_q;
        retired_d = retired_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                cnt_d   = '0;
            end
            ST_FETCH: begin
                if (req_q && imem_ack) begin
                    // Ack beats a timeout landing in the same cycle
                    op_d    = imem_rdata[OPCODE_HI:OPCODE_LO];
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = ST_ISSUE;
                end else if (cnt_q == CNT_LAST) begin
                    // Give up on this wait, flag it, keep requesting the same PC
                    err_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ISSUE: begin
                if (valid_q && dec_ready) begin
                    pc_d      = pc_q + ADDR_W'(4);
                    retired_d = retired_q + 16'd1;
                    illegal_d = illegal_q | ~op_legal;
                    valid_d   = 1'b0;
                    req_d     = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_RESET;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset discards any
    // in-flight fetch or issue without counting it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            pc_q      <= RESET_PC;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            op_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            err_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
            retired_q <= retired_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign dec_valid = valid_q;
    assign illegal   = illegal_q;
    assign fetch_err = err_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: table of instructions plus
// hand-written timeout, wrap and reset-abort sequences.
// Inputs driven and outputs sampled on the falling edge.
module tb_instr_fetch_decode;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (ADDR_W = 16)
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [63:0] dec_onehot;
    logic        dec_valid;
    logic        dec_ready;
    logic        illegal;
    logic        fetch_err;
    logic [15:0] retired;

    // Narrow-address instance for the PC wrap
    logic        rst2_n;
    logic        req2;
    logic [3:0]  addr2;
    logic        ack2;
    logic [31:0] rdata2;
    logic [63:0] onehot2;
    logic        valid2;
    logic        ready2;
    logic        illegal2;
    logic        err2;
    logic [15:0] retired2;

    instr_fetch_decode #(.ADDR_W(16), .TIMEOUT(15), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dec_onehot (dec_onehot),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .illegal    (illegal),
        .fetch_err  (fetch_err),
        .retired    (retired)
    );

    instr_fetch_decode #(.ADDR_W(4), .TIMEOUT(15), .RESET_PC(4'h0)) dut_w (
        .clk        (clk),
        .rst_n      (rst2_n),
        .imem_req   (req2),
        .imem_addr  (addr2),
        .imem_ack   (ack2),
        .imem_rdata (rdata2),
        .dec_onehot (onehot2),
        .dec_valid  (valid2),
        .dec_ready  (ready2),
        .illegal    (illegal2),
        .fetch_err  (err2),
        .retired    (retired2)
    );

    typedef struct {
        logic [5:0]  opcode;
        int          ack_dly;
        int          rdy_dly;
        logic [63:0] exp_onehot;
        logic        exp_legal;
    } vec_t;

    vec_t vecs[12];

    int total = 0;
    int bad   = 0;

    // Reference model of the architectural state
    logic [15:0] pc_m;
    logic [15:0] ret_m;
    logic        ill_m;
    logic        err_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full fetch/issue transaction, entered on a falling edge while in FETCH
    task automatic do_txn(input vec_t v);
        for (int k = 0; k < v.ack_dly; k++) begin
            check("wait_req", imem_req, 1);
            check("wait_addr", imem_addr, pc_m);
            check("wait_err", fetch_err, err_m);
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
        end
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, pc_m);
        imem_ack   = 1'b1;
        imem_rdata = {v.opcode, 26'($urandom)};
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check("issue_valid", dec_valid, 1);
        check("issue_onehot", dec_onehot, v.exp_onehot);
        check("issue_req_low", imem_req, 0);
        check("issue_err", fetch_err, err_m);
        for (int r = 0; r < v.rdy_dly; r++) begin
            dec_ready = 1'b0;
            @(negedge clk);
            check("hold_valid", dec_valid, 1);
            check("hold_onehot", dec_onehot, v.exp_onehot);
            check("hold_addr", imem_addr, pc_m);
            check("hold_retired", retired, ret_m);
        end
        dec_ready = 1'b1;
        @(negedge clk);
        pc_m  = pc_m + 16'd4;
        ret_m = ret_m + 16'd1;
        if (!v.exp_legal) ill_m = 1'b1;
        check("done_valid", dec_valid, 0);
        check("done_req", imem_req, 1);
        check("done_addr", imem_addr, pc_m);
        check("done_retired", retired, ret_m);
        check("done_illegal", illegal, ill_m);
    endtask

    initial begin
        logic [3:0] exp_addr2 [5];

        vecs[0]  = '{6'd4,  0,  0, 64'h0000_0000_0000_0010, 1'b1};
        vecs[1]  = '{6'd36, 0,  0, 64'h0000_0010_0000_0000, 1'b1};
        vecs[2]  = '{6'd60, 0,  0, 64'h1000_0000_0000_0000, 1'b1};
        vecs[3]  = '{6'd11, 0,  5, 64'h0000_0000_0000_0800, 1'b1};
        vecs[4]  = '{6'd7,  0,  0, 64'h0000_0000_0000_0000, 1'b0};
        vecs[5]  = '{6'd12, 0,  0, 64'h0000_0000_0000_1000, 1'b1};
        vecs[6]  = '{6'd5,  3,  0, 64'h0000_0000_0000_0020, 1'b1};
        vecs[7]  = '{6'd15, 0,  2, 64'h0000_0000_0000_8000, 1'b1};
        vecs[8]  = '{6'd24, 1,  0, 64'h0000_0000_0100_0000, 1'b1};
        vecs[9]  = '{6'd0,  0,  0, 64'h0000_0000_0000_0000, 1'b0};
        vecs[10] = '{6'd63, 0,  1, 64'h0000_0000_0000_0000, 1'b0};
        vecs[11] = '{6'd36, 14, 0, 64'h0000_0000_0010_0000_0000 >> 0, 1'b1};

        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        dec_ready  = 1'b0;
        rst2_n     = 1'b0;
        ack2       = 1'b1;
        ready2     = 1'b1;
        rdata2     = 32'h1000_0000;

        // Reset held for three cycles with random inputs
        for (int i = 0; i < 3; i++) begin
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            dec_ready  = 1'($urandom);
            @(negedge clk);
            check("rst_req", imem_req, 0);
            check("rst_addr", imem_addr, 16'h0000);
            check("rst_valid", dec_valid, 0);
            check("rst_onehot", dec_onehot, 64'h0);
            check("rst_illegal", illegal, 0);
            check("rst_err", fetch_err, 0);
            check("rst_retired", retired, 16'h0000);
        end
        rst_n     = 1'b1;
        imem_ack  = 1'b0;
        dec_ready = 1'b0;
        check("rel_req_low", imem_req, 0);
        @(negedge clk);
        check("rel_req", imem_req, 1);
        check("rel_addr", imem_addr, 16'h0000);
        check("rel_valid", dec_valid, 0);

        pc_m  = 16'h0000;
        ret_m = 16'h0000;
        ill_m = 1'b0;
        err_m = 1'b0;

        // Table: back-to-back, backpressure, illegal, ack latency up to the limit
        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i]);
        end

        // Fifteen unacked cycles: fetch_err sets, same address re-requested
        imem_ack = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check("to_req", imem_req, 1);
            check("to_addr", imem_addr, pc_m);
            check("to_err_pre", fetch_err, 0);
            imem_rdata = $urandom;
            @(negedge clk);
        end
        err_m = 1'b1;
        check("to_err", fetch_err, 1);
        check("to_req_again", imem_req, 1);
        check("to_addr_again", imem_addr, pc_m);
        do_txn(vecs[5]);

        // Retired counter wraps 0xFFFF -> 0x0000
        force dut.retired_q = 16'hFFFF;
        #1;
        release dut.retired_q;
        ret_m = 16'hFFFF;
        do_txn(vecs[0]);
        check("ret_wrap", retired, 16'h0000);
        do_txn(vecs[8]);

        // Reset during ISSUE: pending instruction discarded, state back to reset values
        imem_ack   = 1'b1;
        imem_rdata = {6'd60, 26'h0};
        dec_ready  = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        check("abort_pre_valid", dec_valid, 1);
        check("abort_pre_retired", retired, ret_m);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_valid", dec_valid, 0);
        check("abort_onehot", dec_onehot, 64'h0);
        check("abort_req", imem_req, 0);
        check("abort_addr", imem_addr, 16'h0000);
        check("abort_retired", retired, 16'h0000);
        check("abort_illegal", illegal, 0);
        check("abort_err", fetch_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_refetch_req", imem_req, 1);
        check("abort_refetch_addr", imem_addr, 16'h0000);

        // 4-bit PC: 0, 4, 8, 12 then back to 0
        exp_addr2[0] = 4'd0;
        exp_addr2[1] = 4'd4;
        exp_addr2[2] = 4'd8;
        exp_addr2[3] = 4'd12;
        exp_addr2[4] = 4'd0;
        rst2_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("w_req", req2, 1);
            check("w_addr", addr2, exp_addr2[i]);
            @(negedge clk);
            check("w_valid", valid2, 1);
            check("w_onehot", onehot2, 64'h10);
        end
        check("w_retired", retired2, 16'd4);
        check("w_illegal", illegal2, 0);
        check("w_err", err2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
